// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_mem_pkg
// Brief  : Shared owner encoding and constants for the memory port arbiter.
// Rev    : 1.0
// ============================================================================
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int unsigned c_def_max_wait = 4;
  // Byte address -> word address: low two bits are dropped.
  localparam int unsigned c_word_lsb     = 2;
  // Wide enough for the largest legal MAX_WAIT (15).
  localparam int unsigned c_wait_w       = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_starve_ctr
// Brief  : Saturating count of consecutive refused fetch cycles.
// Rev    : 1.0
// ============================================================================
module mem_arb_starve_ctr
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = c_def_max_wait
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [c_wait_w-1:0] c_max = c_wait_w'(MAX_WAIT);

  logic [c_wait_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_max = (r_cnt == c_max);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one synchronous-read memory port between fetch and data.
// Rev    : 1.0
// ============================================================================
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned MAX_WAIT = c_def_max_wait
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              stall
);

  logic   w_at_max;
  logic   w_if_gnt;
  logic   w_d_gnt;
  owner_e r_owner;
  owner_e w_owner_nxt;
  logic   w_unused;

  // Data wins unless fetch has been refused MAX_WAIT cycles in a row.
  assign w_if_gnt = !rst && if_req && (!d_req || w_at_max);
  assign w_d_gnt  = !rst && d_req && !w_if_gnt;

  mem_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (if_req && !w_if_gnt),
    .clr    (w_if_gnt || !if_req),
    .at_max (w_at_max)
  );

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 4'b0;
    mem_addr = '0;
    mem_din  = 32'b0;
    if (w_if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[c_word_lsb +: ADDR_W];
    end else if (w_d_gnt) begin
      mem_en   = 1'b1;
      mem_we   = d_we;
      mem_addr = d_addr[c_word_lsb +: ADDR_W];
      mem_din  = d_wdata;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_if_gnt) begin
      w_owner_nxt = OWN_IF;
    end else if (w_d_gnt && (d_we == 4'b0)) begin
      w_owner_nxt = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Gating with rst drops a read response whose grant preceded reset.
  assign if_rvalid = !rst && (r_owner == OWN_IF);
  assign d_rvalid  = !rst && (r_owner == OWN_D);
  assign if_rdata  = mem_dout;
  assign d_rdata   = mem_dout;

  assign if_gnt = w_if_gnt;
  assign d_gnt  = w_d_gnt;
  assign stall  = !rst && ((if_req && !w_if_gnt) || (d_req && !w_d_gnt));

  assign w_unused = ^{if_addr[c_word_lsb-1:0], if_addr[31:ADDR_W+c_word_lsb],
                      d_addr[c_word_lsb-1:0], d_addr[31:ADDR_W+c_word_lsb]};

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed plus random requests checked against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  localparam int ADDR_W   = 14;
  localparam int MAX_WAIT = 4;
  localparam int NWORDS   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req = 1'b0;
  logic [3:0]        d_we = '0;
  logic [31:0]       d_addr = '0;
  logic [31:0]       d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout = '0;
  logic              stall;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .stall(stall)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT, and the model's own copy of it.
  logic [31:0] mem     [NWORDS];
  logic [31:0] ref_mem [NWORDS];

  always @(posedge clk) begin
    logic [31:0] nw;
    if (mem_en) begin
      if (mem_we == 4'b0) begin
        mem_dout <= mem[mem_addr];
      end else begin
        nw = mem[mem_addr];
        for (int b = 0; b < 4; b++) if (mem_we[b]) nw[8*b +: 8] = mem_din[8*b +: 8];
        mem[mem_addr] <= nw;
      end
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state: refused-fetch streak, pending response owner and its data.
  int unsigned m_wait   = 0;
  bit          m_if_pend = 0;
  bit          m_d_pend  = 0;
  logic [31:0] m_rdata  = '0;
  bit          eg_if, eg_d;

  task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                      input bit dr, input logic [3:0] dwe,
                      input logic [31:0] da, input logic [31:0] dwd);
    int unsigned wi, wd;
    bit          e_stall;
    logic [31:0] e_addr, e_din;
    logic [3:0]  e_we;
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    #1;
    wi = (ia / 4) % NWORDS;
    wd = (da / 4) % NWORDS;
    if (r) begin
      eg_if = 0; eg_d = 0;
    end else begin
      eg_if = ir && (!dr || m_wait >= MAX_WAIT);
      eg_d  = dr && !eg_if;
    end
    e_stall = !r && ((ir && !eg_if) || (dr && !eg_d));
    e_addr  = eg_if ? wi : (eg_d ? wd : 0);
    e_we    = eg_d ? dwe : 4'b0;
    e_din   = eg_d ? dwd : 32'b0;
    check("if_gnt",    if_gnt,    eg_if);
    check("d_gnt",     d_gnt,     eg_d);
    check("mem_en",    mem_en,    eg_if || eg_d);
    check("mem_we",    mem_we,    e_we);
    check("mem_addr",  mem_addr,  e_addr);
    check("mem_din",   mem_din,   e_din);
    check("stall",     stall,     e_stall);
    check("if_rvalid", if_rvalid, !r && m_if_pend);
    check("d_rvalid",  d_rvalid,  !r && m_d_pend);
    if (!r && m_if_pend) check("if_rdata", if_rdata, m_rdata);
    if (!r && m_d_pend)  check("d_rdata",  d_rdata,  m_rdata);
    if (r) begin
      m_wait = 0; m_if_pend = 0; m_d_pend = 0;
    end else begin
      m_wait    = (ir && !eg_if) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      m_if_pend = eg_if;
      m_d_pend  = eg_d && (dwe == 4'b0);
      if (eg_if) m_rdata = ref_mem[wi];
      else if (eg_d && dwe == 4'b0) m_rdata = ref_mem[wd];
      else if (eg_d)
        for (int b = 0; b < 4; b++) if (dwe[b]) ref_mem[wd][8*b +: 8] = dwd[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[15:8] = 8'h00;
    return a;
  endfunction

  initial begin
    bit          ir, dr, r;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dwe;
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end

    // Requests during reset must be ignored.
    step(1, 1, 32'h10, 1, 4'h0, 32'h20, 32'h0);
    step(1, 1, 32'h10, 1, 4'h0, 32'h20, 32'h0);
    // Fetch only, then its response.
    step(0, 1, 32'h0000_0010, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    // Partial store, no response.
    step(0, 0, 32'h0, 1, 4'b0011, 32'h104, 32'hDEAD_BEEF);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    // Read-back of the stored word.
    step(0, 0, 32'h0, 1, 4'h0, 32'h104, 32'h0);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    // Two-cycle data burst against a waiting fetch.
    step(0, 1, 32'h20, 1, 4'h0, 32'h30, 32'h0);
    step(0, 1, 32'h20, 1, 4'h0, 32'h34, 32'h0);
    step(0, 1, 32'h20, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    // Continuous contention: fetch wins every fifth cycle.
    for (int i = 0; i < 15; i++) step(0, 1, 32'h40 + 4 * i, 1, 4'h0, 32'h80 + 4 * i, 32'h0);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    // Alternating owners.
    step(0, 1, 32'h8, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 1, 4'h0, 32'hC, 32'h0);
    step(0, 1, 32'h14, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    // Read granted right before reset yields no response.
    step(0, 0, 32'h0, 1, 4'h0, 32'h18, 32'h0);
    step(1, 1, 32'h1C, 1, 4'h0, 32'h18, 32'h0);
    step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 1, 32'h1C, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

    // Random traffic; requests held until granted, occasional drops and resets.
    ir = 0; dr = 0; ia = '0; da = '0; dwd = '0; dwe = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!ir && $urandom_range(0, 2) != 0) begin
        ir = 1; ia = rand_addr();
      end
      if (!dr && $urandom_range(0, 3) != 0) begin
        dr = 1; da = rand_addr(); dwd = $urandom;
        dwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      r = ($urandom_range(0, 299) == 0);
      step(r, ir, ia, dr, dwe, da, dwd);
      if (eg_if || r) ir = 0;
      if (eg_d || r) dr = 0;
      if (ir && $urandom_range(0, 19) == 0) ir = 0;
      if (dr && $urandom_range(0, 19) == 0) dr = 0;
    end
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
